// File: rtl/vlsu_ax_gen.sv
// AXI4 address-beat generator for the VLSU: turns page-bounded transaction
// descriptors into single INCR beats on AR (loads) or AW (stores), holding one
// registered output slot and bounding the number of in-flight transactions
// per direction.
module vlsu_ax_gen #(
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiDataWidth   = 256,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned AxiId          = 0,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    txn_valid_i,
    output logic                    txn_ready_o,
    input  logic                    txn_is_load_i,
    input  logic [AxiAddrWidth:0]   txn_seg_base_i,
    input  logic [7:0]              txn_cnt_i,
    input  logic [7:0]              txn_num_i,
    input  logic [13:0]             txn_ltn_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [AxiAddrWidth-1:0] ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [2:0]              ar_size_o,
    output logic [1:0]              ar_burst_o,
    output logic [AxiIdWidth-1:0]   ar_id_o,
    output logic                    aw_valid_o,
    input  logic                    aw_ready_i,
    output logic [AxiAddrWidth-1:0] aw_addr_o,
    output logic [7:0]              aw_len_o,
    output logic [2:0]              aw_size_o,
    output logic [1:0]              aw_burst_o,
    output logic [AxiIdWidth-1:0]   aw_id_o,
    input  logic                    rd_done_i,
    input  logic                    wr_done_i,
    output logic [7:0]              rd_outstanding_o,
    output logic [7:0]              wr_outstanding_o,
    output logic                    idle_o
);

    localparam int unsigned BeatNibbles = AxiDataWidth / 4;
    localparam int unsigned BeatBits    = $clog2(BeatNibbles);
    localparam int unsigned PageWidth   = AxiAddrWidth - 12;
    localparam logic [2:0]  SizeVal     = 3'($clog2(AxiDataWidth / 8));
    localparam logic [7:0]  MaxOut      = 8'(MaxOutstanding);
    localparam logic [AxiIdWidth-1:0] IdVal = AxiIdWidth'(AxiId);

    logic                    valid_q, valid_d;
    logic                    is_load_q, is_load_d;
    logic [AxiAddrWidth-1:0] addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              rd_cnt_q, rd_cnt_d;
    logic [7:0]              wr_cnt_q, wr_cnt_d;

    logic [PageWidth-1:0]    page_sum;
    logic [AxiAddrWidth:0]   start;
    logic [13:0]             start_off, end_off, nibbles;
    logic [BeatBits-1:0]     beat_off;
    logic [AxiAddrWidth-1:0] dec_addr;
    logic [7:0]              dec_len;
    logic                    fire, accept, rd_inc, wr_inc, rd_dec, wr_dec;
    logic [7:0]              cnt_dir;

    // Descriptor decode: nibble start/length into a beat-aligned byte burst.
    always_comb begin
        page_sum  = txn_seg_base_i[AxiAddrWidth:13] + PageWidth'(txn_cnt_i);
        start     = (txn_cnt_i == 8'd0) ? txn_seg_base_i : {page_sum, 13'b0};
        start_off = (txn_cnt_i == 8'd0) ? {1'b0, txn_seg_base_i[12:0]} : 14'd0;
        end_off   = (txn_cnt_i == txn_num_i) ? txn_ltn_i : 14'd8192;
        nibbles   = end_off - start_off;
        beat_off  = start[BeatBits-1:0];
        // Round the start down to a beat; the >>1 turns nibbles into bytes.
        dec_addr  = {start[AxiAddrWidth:BeatBits], {(BeatBits - 1){1'b0}}};
        dec_len   = 8'((15'(beat_off) + 15'(nibbles) - 15'd1) >> BeatBits);
    end

    // Handshake, slot next-state and outstanding counter next-state.
    always_comb begin
        fire        = valid_q & (is_load_q ? ar_ready_i : aw_ready_i);
        cnt_dir     = txn_is_load_i ? rd_cnt_q : wr_cnt_q;
        txn_ready_o = (!valid_q | fire) & (cnt_dir < MaxOut);
        accept      = txn_valid_i & txn_ready_o;

        valid_d   = valid_q;
        is_load_d = is_load_q;
        addr_d    = addr_q;
        len_d     = len_q;
        if (accept) begin
            valid_d   = 1'b1;
            is_load_d = txn_is_load_i;
            addr_d    = dec_addr;
            len_d     = dec_len;
        end else if (fire) begin
            valid_d = 1'b0;
        end

        rd_inc = accept & txn_is_load_i;
        wr_inc = accept & !txn_is_load_i;
        // Done pulses at zero are dropped so the counters saturate.
        rd_dec = rd_done_i & (rd_cnt_q != 8'd0);
        wr_dec = wr_done_i & (wr_cnt_q != 8'd0);

        rd_cnt_d = rd_cnt_q;
        if (rd_inc && !rd_dec) rd_cnt_d = rd_cnt_q + 8'd1;
        else if (rd_dec && !rd_inc) rd_cnt_d = rd_cnt_q - 8'd1;

        wr_cnt_d = wr_cnt_q;
        if (wr_inc && !wr_dec) wr_cnt_d = wr_cnt_q + 8'd1;
        else if (wr_dec && !wr_inc) wr_cnt_d = wr_cnt_q - 8'd1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            is_load_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            is_load_q <= is_load_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Both channels share the slot fields; only the valids are steered.
    always_comb begin
        ar_valid_o       = valid_q & is_load_q;
        aw_valid_o       = valid_q & !is_load_q;
        ar_addr_o        = addr_q;
        aw_addr_o        = addr_q;
        ar_len_o         = len_q;
        aw_len_o         = len_q;
        ar_size_o        = SizeVal;
        aw_size_o        = SizeVal;
        ar_burst_o       = 2'b01;
        aw_burst_o       = 2'b01;
        ar_id_o          = IdVal;
        aw_id_o          = IdVal;
        rd_outstanding_o = rd_cnt_q;
        wr_outstanding_o = wr_cnt_q;
        idle_o           = !valid_q & (rd_cnt_q == 8'd0) & (wr_cnt_q == 8'd0);
    end

endmodule

// File: tb/tb_vlsu_ax_gen.sv
// Self-checking bench for vlsu_ax_gen: directed cases, limit/reset scenarios
// and a randomized phase against a nibble-range reference model.
module tb_vlsu_ax_gen;

    localparam int unsigned MaxOut = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        txn_valid_i, txn_ready_o, txn_is_load_i;
    logic [64:0] txn_seg_base_i;
    logic [7:0]  txn_cnt_i, txn_num_i;
    logic [13:0] txn_ltn_i;
    logic        ar_valid_o, ar_ready_i, aw_valid_o, aw_ready_i;
    logic [63:0] ar_addr_o, aw_addr_o;
    logic [7:0]  ar_len_o, aw_len_o;
    logic [2:0]  ar_size_o, aw_size_o;
    logic [1:0]  ar_burst_o, aw_burst_o;
    logic [3:0]  ar_id_o, aw_id_o;
    logic        rd_done_i, wr_done_i, idle_o;
    logic [7:0]  rd_outstanding_o, wr_outstanding_o;

    int n_checks = 0;
    int n_err    = 0;

    vlsu_ax_gen #(
        .AxiAddrWidth  (64),
        .AxiDataWidth  (256),
        .AxiIdWidth    (4),
        .AxiId         (0),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .txn_valid_i     (txn_valid_i),
        .txn_ready_o     (txn_ready_o),
        .txn_is_load_i   (txn_is_load_i),
        .txn_seg_base_i  (txn_seg_base_i),
        .txn_cnt_i       (txn_cnt_i),
        .txn_num_i       (txn_num_i),
        .txn_ltn_i       (txn_ltn_i),
        .ar_valid_o      (ar_valid_o),
        .ar_ready_i      (ar_ready_i),
        .ar_addr_o       (ar_addr_o),
        .ar_len_o        (ar_len_o),
        .ar_size_o       (ar_size_o),
        .ar_burst_o      (ar_burst_o),
        .ar_id_o         (ar_id_o),
        .aw_valid_o      (aw_valid_o),
        .aw_ready_i      (aw_ready_i),
        .aw_addr_o       (aw_addr_o),
        .aw_len_o        (aw_len_o),
        .aw_size_o       (aw_size_o),
        .aw_burst_o      (aw_burst_o),
        .aw_id_o         (aw_id_o),
        .rd_done_i       (rd_done_i),
        .wr_done_i       (wr_done_i),
        .rd_outstanding_o(rd_outstanding_o),
        .wr_outstanding_o(wr_outstanding_o),
        .idle_o          (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input bit ld, input logic [64:0] base, input logic [7:0] c,
                         input logic [7:0] n, input logic [13:0] l);
        txn_valid_i    = 1'b1;
        txn_is_load_i  = ld;
        txn_seg_base_i = base;
        txn_cnt_i      = c;
        txn_num_i      = n;
        txn_ltn_i      = l;
    endtask

    // Reference: work in absolute nibble ranges [start, end) and count the
    // beats those ranges touch.
    task automatic ref_beat(input logic [64:0] base, input logic [7:0] c, input logic [7:0] n,
                            input logic [13:0] l, output logic [63:0] addr,
                            output logic [7:0] len);
        logic [64:0] page_start, s, e, first_beat, last_beat;
        page_start = base - (base % 65'd8192);
        s = (c == 0) ? base : page_start + 65'(c) * 65'd8192;
        e = (c == n) ? page_start + 65'(n) * 65'd8192 + 65'(l)
                     : page_start + (65'(c) + 65'd1) * 65'd8192;
        first_beat = s / 65'd64;
        last_beat  = (e - 65'd1) / 65'd64;
        len  = 8'(last_beat - first_beat);
        addr = 64'(first_beat * 65'd32);
    endtask

    task automatic run_directed(input string tag, input bit ld, input logic [64:0] base,
                                input logic [7:0] c, input logic [7:0] n,
                                input logic [13:0] l, input logic [63:0] exp_addr,
                                input logic [7:0] exp_len);
        ar_ready_i = 1'b0;
        aw_ready_i = 1'b0;
        drive(ld, base, c, n, l);
        #1;
        check({tag, "_rdy"}, 64'(txn_ready_o), 64'd1);
        step();
        txn_valid_i = 1'b0;
        #1;
        for (int h = 0; h < 2; h++) begin
            check({tag, "_arv"}, 64'(ar_valid_o), 64'(ld));
            check({tag, "_awv"}, 64'(aw_valid_o), 64'(!ld));
            check({tag, "_addr"}, ld ? ar_addr_o : aw_addr_o, exp_addr);
            check({tag, "_len"}, 64'(ld ? ar_len_o : aw_len_o), 64'(exp_len));
            check({tag, "_size"}, 64'(ld ? ar_size_o : aw_size_o), 64'd5);
            check({tag, "_burst"}, 64'(ld ? ar_burst_o : aw_burst_o), 64'd1);
            check({tag, "_id"}, 64'(ld ? ar_id_o : aw_id_o), 64'd0);
            step();
        end
        // Handshake and completion in the same cycle, then expect idle.
        if (ld) begin ar_ready_i = 1'b1; rd_done_i = 1'b1; end
        else begin aw_ready_i = 1'b1; wr_done_i = 1'b1; end
        step();
        ar_ready_i = 1'b0; aw_ready_i = 1'b0; rd_done_i = 1'b0; wr_done_i = 1'b0;
        #1;
        check({tag, "_drained"}, 64'(ar_valid_o | aw_valid_o), 64'd0);
        check({tag, "_idle"}, 64'(idle_o), 64'd1);
    endtask

    task automatic rand_desc(output bit ld, output logic [64:0] base, output logic [7:0] c,
                             output logic [7:0] n, output logic [13:0] l);
        int unsigned off;
        ld   = 1'($urandom);
        off  = $urandom_range(0, 8191);
        base = {3'b000, 30'($urandom), 19'($urandom), 13'(off)};
        n    = 8'($urandom_range(0, 3));
        c    = 8'($urandom_range(0, n));
        if (n == 0) l = 14'($urandom_range(off + 1, 8192));
        else        l = 14'($urandom_range(1, 8192));
    endtask

    initial begin
        bit          m_valid, m_ld, r_ld, exp_rdy, fire, acc;
        logic [63:0] m_addr, r_addr;
        logic [7:0]  m_len, r_len;
        int          m_rd, m_wr;
        logic [64:0] r_base;
        logic [7:0]  r_c, r_n;
        logic [13:0] r_l;

        rst_ni = 1'b0;
        txn_valid_i = 1'b0; txn_is_load_i = 1'b0; txn_seg_base_i = '0;
        txn_cnt_i = '0; txn_num_i = '0; txn_ltn_i = '0;
        ar_ready_i = 1'b0; aw_ready_i = 1'b0; rd_done_i = 1'b0; wr_done_i = 1'b0;
        step();
        step();
        check("rst_idle", 64'(idle_o), 64'd1);
        check("rst_arv", 64'(ar_valid_o), 64'd0);
        check("rst_awv", 64'(aw_valid_o), 64'd0);
        check("rst_addr", ar_addr_o, 64'd0);
        check("rst_len", 64'(aw_len_o), 64'd0);
        check("rst_rd", 64'(rd_outstanding_o), 64'd0);
        check("rst_wr", 64'(wr_outstanding_o), 64'd0);
        rst_ni = 1'b1;
        step();

        run_directed("basic", 1'b1, 65'h100, 8'd0, 8'd0, 14'h140, 64'h80, 8'd0);
        run_directed("pg_a", 1'b1, 65'h1FC0, 8'd0, 8'd1, 14'h40, 64'hFE0, 8'd0);
        run_directed("pg_b", 1'b1, 65'h1FC0, 8'd1, 8'd1, 14'h40, 64'h1000, 8'd0);
        run_directed("mis_st", 1'b0, 65'h10, 8'd0, 8'd0, 14'h90, 64'h0, 8'd2);
        run_directed("full_pg", 1'b1, 65'h2000, 8'd1, 8'd2, 14'h100, 64'h2000, 8'd127);

        // Outstanding limit on the read side.
        ar_ready_i = 1'b1;
        drive(1'b1, 65'h100, 8'd0, 8'd0, 14'h140);
        #1 check("lim_rdy0", 64'(txn_ready_o), 64'd1);
        step();
        check("lim_rdy1", 64'(txn_ready_o), 64'd1);
        step();
        check("lim_stall", 64'(txn_ready_o), 64'd0);
        check("lim_rd2", 64'(rd_outstanding_o), 64'd2);
        txn_is_load_i = 1'b0;
        #1 check("lim_other_dir", 64'(txn_ready_o), 64'd1);
        txn_is_load_i = 1'b1;
        rd_done_i = 1'b1;
        #1 check("lim_stall_done", 64'(txn_ready_o), 64'd0);
        step();
        rd_done_i = 1'b0;
        #1 check("lim_rd1", 64'(rd_outstanding_o), 64'd1);
        check("lim_resume", 64'(txn_ready_o), 64'd1);
        step();
        check("lim_rd2b", 64'(rd_outstanding_o), 64'd2);
        rd_done_i = 1'b1;
        step();
        check("lim_rd1b", 64'(rd_outstanding_o), 64'd1);
        check("lim_rdy_incdec", 64'(txn_ready_o), 64'd1);
        step();
        check("lim_inc_dec", 64'(rd_outstanding_o), 64'd1);
        txn_valid_i = 1'b0;
        step();
        check("lim_rd0", 64'(rd_outstanding_o), 64'd0);
        step();
        check("sat_rd0", 64'(rd_outstanding_o), 64'd0);
        rd_done_i = 1'b0;
        ar_ready_i = 1'b0;
        #1 check("lim_idle", 64'(idle_o), 64'd1);

        // Reset while an AW is pending.
        drive(1'b0, 65'h10, 8'd0, 8'd0, 14'h90);
        step();
        txn_valid_i = 1'b0;
        check("rs_awv_pre", 64'(aw_valid_o), 64'd1);
        check("rs_wr_pre", 64'(wr_outstanding_o), 64'd1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        check("rs_awv", 64'(aw_valid_o), 64'd0);
        check("rs_wr", 64'(wr_outstanding_o), 64'd0);
        check("rs_idle", 64'(idle_o), 64'd1);
        wr_done_i = 1'b1;
        step();
        wr_done_i = 1'b0;
        check("rs_sat_wr", 64'(wr_outstanding_o), 64'd0);

        // Randomized traffic against the reference model.
        m_valid = 1'b0; m_ld = 1'b0; m_addr = '0; m_len = '0; m_rd = 0; m_wr = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rand_desc(r_ld, r_base, r_c, r_n, r_l);
            drive(r_ld, r_base, r_c, r_n, r_l);
            txn_valid_i = ($urandom_range(0, 3) != 0);
            ar_ready_i  = ($urandom_range(0, 2) != 0);
            aw_ready_i  = ($urandom_range(0, 2) != 0);
            rd_done_i   = ($urandom_range(0, 2) == 0);
            wr_done_i   = ($urandom_range(0, 2) == 0);
            #1;
            fire    = m_valid && (m_ld ? ar_ready_i : aw_ready_i);
            exp_rdy = (!m_valid || fire) && ((r_ld ? m_rd : m_wr) < MaxOut);
            check("rnd_rdy", 64'(txn_ready_o), 64'(exp_rdy));
            check("rnd_arv", 64'(ar_valid_o), 64'(m_valid && m_ld));
            check("rnd_awv", 64'(aw_valid_o), 64'(m_valid && !m_ld));
            check("rnd_rd", 64'(rd_outstanding_o), 64'(m_rd));
            check("rnd_wr", 64'(wr_outstanding_o), 64'(m_wr));
            if (m_valid) begin
                check("rnd_addr", m_ld ? ar_addr_o : aw_addr_o, m_addr);
                check("rnd_len", 64'(m_ld ? ar_len_o : aw_len_o), 64'(m_len));
            end
            acc = txn_valid_i && exp_rdy;
            if (acc) begin
                ref_beat(r_base, r_c, r_n, r_l, r_addr, r_len);
                m_valid = 1'b1; m_ld = r_ld; m_addr = r_addr; m_len = r_len;
            end else if (fire) begin
                m_valid = 1'b0;
            end
            m_rd = m_rd + ((acc && r_ld) ? 1 : 0) - ((rd_done_i && m_rd > 0) ? 1 : 0);
            m_wr = m_wr + ((acc && !r_ld) ? 1 : 0) - ((wr_done_i && m_wr > 0) ? 1 : 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
